// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin byte scheduler in front of a UART
// parallel-in/serial-out serializer.
//
// Parameters:
//   TIMEOUT_CYCLES   baud_clk cycles allowed from piso_send rising to
//                    piso_done before the frame is aborted.
// Build option:
//   TX_TIMEOUT_EN    define to enable the abort timer; when undefined
//                    there is no timer, tx_err_o is tied 0 and the
//                    scheduler waits for the serializer indefinitely.
// Ports:
//   baud_clk_i, reset_n_i          clock (rising edge), async active-low reset
//   cfg_parity_type_i[1:0]         00/11 none, 01 odd, 10 even
//   reqN_valid_i, reqN_data_i[7:0] requester N byte offer (N = 0,1)
//   reqN_ready_o                   byte accepted on valid && ready
//   piso_send_o                    start request to the serializer
//   piso_data_o[7:0]               byte to serialize
//   piso_parity_bit_o              parity bit to serialize
//   piso_parity_type_o[1:0]        parity mode latched with the byte
//   piso_active_i, piso_done_i     serializer frame in progress / complete
//   tx_done_o, tx_err_o            one-cycle completion / abort pulses
//   tx_id_o                        requester of the last completed/aborted frame
//   busy_o                         high whenever not IDLE
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for a requester while the serializer is quiet
// LOAD     | byte, parity and id latched; serializer inputs settle
// WAIT_ACT | piso_send high until the serializer reports active
// BUSY     | frame on the wire, waiting for piso_done
// DONE     | tx_done pulse, pointer moves to the other requester

module uart_tx_sched #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       baud_clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] cfg_parity_type_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       piso_send_o,
  output logic [7:0] piso_data_o,
  output logic       piso_parity_bit_o,
  output logic [1:0] piso_parity_type_o,
  input  logic       piso_active_i,
  input  logic       piso_done_i,
  output logic       tx_done_o,
  output logic       tx_id_o,
  output logic       tx_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WAIT_ACT = 3'd2,
    S_BUSY     = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       ptr_q;
  logic       id_q;
  logic [7:0] data_q;
  logic       par_q;
  logic [1:0] type_q;

  logic       gnt_id;
  logic       hs;
  logic       abort;
  logic [7:0] sel_data;

  function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] t);
    case (t)
      2'b01:   return ~^d;
      2'b10:   return ^d;
      default: return 1'b1;
    endcase
  endfunction

  // On contention the pointer decides; a lone valid wins regardless.
  always_comb begin
    if (req0_valid_i && req1_valid_i) gnt_id = ptr_q;
    else                              gnt_id = req1_valid_i;
  end

  // Ready is gated by reset so nothing is offered while reset is held.
  assign hs = reset_n_i && (state_q == S_IDLE) && !piso_active_i && !piso_done_i &&
              (req0_valid_i || req1_valid_i);
  assign req0_ready_o = hs && !gnt_id;
  assign req1_ready_o = hs && gnt_id;
  assign sel_data     = gnt_id ? req1_data_i : req0_data_i;

`ifdef TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Loaded so that reaching zero marks the TIMEOUT_CYCLES-th cycle of piso_send/BUSY.
  always_ff @(posedge baud_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (state_q == S_LOAD)
        cnt_q <= CW'(TIMEOUT_CYCLES - 1);
      else if ((state_q == S_WAIT_ACT || state_q == S_BUSY) && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // piso_done on the last allowed cycle still completes the frame.
  assign abort    = (cnt_q == '0) &&
                    ((state_q == S_WAIT_ACT) || (state_q == S_BUSY && !piso_done_i));
  assign tx_err_o = err_q;
`else
  assign abort    = 1'b0;
  assign tx_err_o = 1'b0;
`endif

  always_ff @(posedge baud_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= 8'h00;
      par_q   <= 1'b1;
      type_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (hs) begin
        data_q <= sel_data;
        par_q  <= calc_parity(sel_data, cfg_parity_type_i);
        type_q <= cfg_parity_type_i;
        id_q   <= gnt_id;
      end
      if (state_q == S_DONE || abort)
        ptr_q <= ~id_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (hs) state_d = S_LOAD;
      S_LOAD:     state_d = S_WAIT_ACT;
      S_WAIT_ACT: begin
        if (abort)              state_d = S_IDLE;
        else if (piso_active_i) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (piso_done_i) state_d = S_DONE;
        else if (abort)  state_d = S_IDLE;
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    piso_send_o        = (state_q == S_WAIT_ACT);
    tx_done_o          = (state_q == S_DONE);
    busy_o             = (state_q != S_IDLE);
    tx_id_o            = id_q;
    piso_data_o        = data_q;
    piso_parity_bit_o  = par_q;
    piso_parity_type_o = type_q;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, baud_clk cycles allowed from piso_send assertion to piso_done before abort.
REQ-002 baud_clk  input  1  sole clock, rising-edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cfg_parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-005 req0_valid / req1_valid  input  1  requester has a byte.
REQ-006 req0_data / req1_data  input  8  requester byte.
REQ-007 req0_ready / req1_ready  output  1  byte accepted when valid&&ready.
REQ-008 piso_send  output  1  start request to the serializer.
REQ-009 piso_data  output  8  byte to the serializer.
REQ-010 piso_parity_bit  output  1  parity bit to the serializer.
REQ-011 piso_parity_type  output  2  parity mode to the serializer.
REQ-012 piso_active  input  1  serializer frame in progress.
REQ-013 piso_done  input  1  serializer frame complete.
REQ-014 tx_done  output  1  one-cycle pulse, frame completed.
REQ-015 tx_id  output  1  requester index of the last completed/aborted frame.
REQ-016 tx_err  output  1  one-cycle pulse, frame aborted on timeout.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, LOAD, WAIT_ACT, BUSY, DONE.
REQ-019 IDLE: grant only when piso_active=0 and piso_done=0; ready is combinational for the granted requester only; handshake edge -> LOAD.
REQ-020 Arbitration is round-robin on a 1-bit pointer; on simultaneous valid, the pointer requester wins; a lone valid always wins.
REQ-021 Pointer moves to the non-granted requester on leaving DONE or on abort; a held valid is served within 2 frames.
REQ-022 Handshake edge latches data, id, cfg_parity_type; cfg changes mid-frame have no effect.
REQ-023 Parity: odd -> ~^data, even -> ^data, none (00/11) -> 1.
REQ-024 LOAD: drive piso_data/parity/type; piso_send rises on the first edge after handshake -> WAIT_ACT.
REQ-025 WAIT_ACT: piso_send held high until piso_active=1 sampled; piso_send low from next cycle -> BUSY.
REQ-026 BUSY: piso_done=1 sampled -> DONE; piso_data/parity/type held stable through BUSY.
REQ-027 DONE: tx_done=1 and tx_id valid for exactly one cycle -> IDLE.
REQ-028 Requester valid dropped after handshake has no effect on the frame in flight.

Reset
REQ-029 reset_n low forces immediately, independent of baud_clk: state IDLE, pointer req0, all outputs 0 except piso_parity_bit=1.
REQ-030 Reset mid-frame aborts without tx_done/tx_err; first grant after release obeys REQ-019.

Configuration
REQ-031 Macro TX_TIMEOUT_EN defined: counter runs in WAIT_ACT and BUSY; when count reaches TIMEOUT_CYCLES without piso_done -> tx_err pulse, tx_id valid, piso_send low, pointer advances, -> IDLE.
REQ-032 TX_TIMEOUT_EN undefined: no counter; tx_err tied 0; WAIT_ACT/BUSY wait indefinitely.

Verification
REQ-033 req0 only, 0x4A, parity 00 -> piso_data=0x4A, parity_bit=1, send 1 cycle after handshake, tx_done, tx_id=0.
REQ-034 req0 and req1 continuously valid (0x5A, 0xA5), parity 01 -> grants 0,1,0,1; parity_bit 1 for 0x5A, 1 for 0xA5.
REQ-035 parity 10, 0x4B, cfg switched to 00 during BUSY -> parity_bit=0 held, type 10 held to done.
REQ-036 TX_TIMEOUT_EN, piso_done never asserted -> tx_err after 16 cycles, send low, next grant to other requester.
REQ-037 reset_n low during BUSY -> outputs reset same cycle, no tx_done; after release, req1 alone granted.
REQ-038 piso_done held high after DONE -> no new grant until it falls.
